useq_sequencer: RTL and testbench
=================================

Name: useq_sequencer

Overview:
- Microprogrammed sequencer that drives datapath control bits from a loadable microcode store.
- Extends the flat next/jump control unit with four additions: a program-load handshake, start/done run control, a loop counter, and a shallow call/return stack.
- Sits between the host or test harness and the datapath. It consumes the datapath condition flag `cres` and produces `dp_ctrl`.

Parameters:
- P_LOG_MEMSIZE, 4: microcode address width. Store depth is 1<<P_LOG_MEMSIZE.
- P_NUM_D_CTRLBITS, 5: datapath control bits per microword.
- P_STACK_DEPTH, 2: call stack entries (1..4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse; begins execution at address 0 when in IDLE.
- cres  in  1  datapath condition flag, sampled by JC.
- ld_valid  in  1  microword write request.
- ld_ready  out  1  store accepts a write this cycle (high only in IDLE).
- ld_addr  in  P_LOG_MEMSIZE  write address.
- ld_data  in  LP_WORDWIDTH  microword; LP_WORDWIDTH = P_NUM_D_CTRLBITS+3+P_LOG_MEMSIZE.
- dp_ctrl  out  P_NUM_D_CTRLBITS  control bits of the current microword; 0 when not in RUN.
- busy  out  1  state == RUN.
- done  out  1  one-cycle pulse after HALT or error terminates execution.
- err  out  1  sticky fault flag (stack overflow/underflow); cleared by start or rst.

Behaviour:
- Microword fields, MSB to LSB:
  - dp field [LP_WORDWIDTH-1 -: D]
  - op [P_LOG_MEMSIZE+2 -: 3]
  - arg [P_LOG_MEMSIZE-1:0]
- Store: register array, no reset, contents survive rst. Combinational read at pc.
- Write: occurs on a cycle with ld_valid && ld_ready. There is no back-pressure other than ld_ready.
- States: IDLE, RUN.
  - IDLE -> RUN on start; pc<=0, err<=0, sp<=0, cnt<=0.
  - RUN -> IDLE on HALT or fault.
  - start while in RUN is ignored.
- Reset: state IDLE, pc 0, sp 0, cnt 0. Outputs: dp_ctrl 0, busy 0, done 0, err 0, ld_ready 1.
- Latency: start sampled at edge N, so cycle N+1 has busy=1 and dp_ctrl=mem[0][dp]. Each RUN cycle executes exactly one microword, with dp_ctrl valid for that cycle.
- Opcodes (pc+1 wraps modulo LP_MEMSIZE; top-of-stack is stack[sp-1]):
  - 0 NEXT: pc<=pc+1.
  - 1 JC: pc<=cres?arg:pc+1.
  - 2 JU: pc<=arg.
  - 3 CALL: if sp<P_STACK_DEPTH, push pc+1, sp++, pc<=arg; else fault.
  - 4 RET: if sp>0, pc<=top-of-stack, sp--; else fault.
  - 5 LOOP: if cnt!=0, cnt--, pc<=arg; else pc<=pc+1.
  - 6 LDCNT: cnt<=arg (width P_LOG_MEMSIZE), pc<=pc+1.
  - 7 HALT: state<=IDLE, done<=1 next cycle; the HALT word's dp bits are still driven during its cycle.
- Fault: err<=1, state<=IDLE, done<=1 next cycle. pc, sp and cnt are left unchanged; start reinitialises them.
- Mid-run rst: behaves exactly as power-on reset. done does not pulse, and microcode is retained.
- done: registered and high for exactly one cycle (the first IDLE cycle after termination).
- ld_valid during RUN: ignored (ld_ready=0). No write occurs and no error is raised.
- start and ld_valid in the same IDLE cycle: both act. The write lands, and execution starts next cycle reading the updated store.

Decomposition:
- Shared package useq_pkg holds:
  - opcode localparams OP_NEXT..OP_HALT (3-bit)
  - state encodings ST_IDLE/ST_RUN
  - field index helpers (LP_WORDWIDTH, LP_OP_IDX, LP_A_IDX, LP_D_IDX)
- One natural sub-module, useq_stack: LIFO with push/pop, full/empty and top outputs, and synchronous reset of sp.
- The store, pc logic and FSM stay in useq_sequencer.

Test Plan:
- Load + straight-line run:
  - Stimulus: mem[0..2] = NEXT dp=5'h01, NEXT dp=5'h02, HALT dp=5'h04; then pulse start.
  - Response: dp_ctrl is 01, 02, 04 on cycles N+1..N+3; busy is 1 on those cycles; done=1 at N+4; busy=0 thereafter.
- Loop:
  - Stimulus: mem[0]=LDCNT arg=3, mem[1]=NEXT dp=5'h10, mem[2]=LOOP arg=1, mem[3]=HALT.
  - Response: the dp=10 word appears 4 times; total RUN cycles = 1+4*2+1 = 10.
- Conditional jump:
  - Stimulus: mem[0]=JC arg=5, mem[5]=HALT, mem[1]=HALT with dp=5'h1F; run once with cres=1, once with cres=0.
  - Response: with cres=1 pc goes to 5 (dp 0 at halt); with cres=0 it halts at 1 with dp_ctrl=1F.
- Call/return and overflow:
  - Stimulus (depth 2): nested CALL, CALL, RET, RET returns correctly to each caller+1. Then a third nested CALL.
  - Response: third CALL gives err=1 and done pulse; busy drops the next cycle.
- RET on empty stack:
  - Stimulus: RET at address 0.
  - Response: err=1 and done=1 on the cycle after start+1.
- Load blocked + reset mid-run:
  - Stimulus: ld_valid during RUN; then assert rst while busy.
  - Response: ld_valid during RUN gives ld_ready=0 and mem is unchanged. After rst: busy=0, done=0, dp_ctrl=0; a re-start re-runs the original program unchanged.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared encodings for the microprogrammed sequencer: opcodes, FSM states and
// microword field layout helpers.
package useq_pkg;

  localparam logic [2:0] OP_NEXT  = 3'd0;
  localparam logic [2:0] OP_JC    = 3'd1;
  localparam logic [2:0] OP_JU    = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_LOOP  = 3'd5;
  localparam logic [2:0] OP_LDCNT = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Field layout, MSB to LSB: {dp[D-1:0], op[2:0], arg[A-1:0]}.
  function automatic int word_width(input int log_memsize, input int num_d_ctrlbits);
    return num_d_ctrlbits + 3 + log_memsize;
  endfunction

  function automatic int op_idx(input int log_memsize);
    return log_memsize + 2;
  endfunction

  function automatic int a_idx(input int log_memsize);
    return log_memsize - 1;
  endfunction

  function automatic int d_idx(input int log_memsize, input int num_d_ctrlbits);
    return word_width(log_memsize, num_d_ctrlbits) - 1;
  endfunction

  // Layout constants for the default geometry (4-bit address, 5 control bits).
  localparam int LP_WORDWIDTH = word_width(4, 5);
  localparam int LP_OP_IDX    = op_idx(4);
  localparam int LP_A_IDX     = a_idx(4);
  localparam int LP_D_IDX     = d_idx(4, 5);

endpackage

// File: rtl/useq_stack.sv
// Shallow LIFO of return addresses. sp resets synchronously and can be
// cleared on a new run; entry storage is not reset.
module useq_stack #(
  parameter int P_DEPTH = 2,
  parameter int P_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [P_WIDTH-1:0] push_data,
  output logic [P_WIDTH-1:0] top,
  output logic               full,
  output logic               empty
);

  localparam int LP_SPW = $clog2(P_DEPTH + 1);

  logic [LP_SPW-1:0]  sp;
  // Sized to the full sp range so indexing by sp never needs truncation.
  logic [P_WIDTH-1:0] entries [1 << LP_SPW];

  assign full  = (sp == LP_SPW'(P_DEPTH));
  assign empty = (sp == '0);
  assign top   = entries[sp - 1'b1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      entries[sp] <= push_data;
    end
  end

endmodule

// File: rtl/useq_sequencer.sv
// Microprogrammed sequencer: loadable microcode store, start/done run control,
// loop counter and call/return stack driving datapath control bits.
module useq_sequencer
  import useq_pkg::*;
#(
  parameter int P_LOG_MEMSIZE    = 4,
  parameter int P_NUM_D_CTRLBITS = 5,
  parameter int P_STACK_DEPTH    = 2
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic                                                cres,
  input  logic                                                ld_valid,
  output logic                                                ld_ready,
  input  logic [P_LOG_MEMSIZE-1:0]                            ld_addr,
  input  logic [word_width(P_LOG_MEMSIZE,P_NUM_D_CTRLBITS)-1:0] ld_data,
  output logic [P_NUM_D_CTRLBITS-1:0]                         dp_ctrl,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                err
);

  localparam int LP_MEMSIZE = 1 << P_LOG_MEMSIZE;
  localparam int LP_WW      = word_width(P_LOG_MEMSIZE, P_NUM_D_CTRLBITS);
  localparam int LP_OPI     = op_idx(P_LOG_MEMSIZE);
  localparam int LP_AI      = a_idx(P_LOG_MEMSIZE);
  localparam int LP_DI      = d_idx(P_LOG_MEMSIZE, P_NUM_D_CTRLBITS);

  // Load handshake: a write happens on any cycle with ld_valid && ld_ready.
  // ld_ready is high only in IDLE; there is no other back-pressure.
  logic [LP_WW-1:0] mem [LP_MEMSIZE];

  state_t                      state, state_nxt;
  logic [P_LOG_MEMSIZE-1:0]    pc, pc_nxt;
  logic [P_LOG_MEMSIZE-1:0]    cnt, cnt_nxt;
  logic                        done_nxt;
  logic                        fault;
  logic                        run_start;
  logic                        push, pop;
  logic                        stk_full, stk_empty;
  logic [P_LOG_MEMSIZE-1:0]    stk_top;

  logic [LP_WW-1:0]            word;
  logic [P_NUM_D_CTRLBITS-1:0] word_dp;
  logic [2:0]                  word_op;
  logic [P_LOG_MEMSIZE-1:0]    word_arg;
  logic [P_LOG_MEMSIZE-1:0]    pc_inc;

  assign word     = mem[pc];
  assign word_dp  = word[LP_DI -: P_NUM_D_CTRLBITS];
  assign word_op  = word[LP_OPI -: 3];
  assign word_arg = word[LP_AI:0];
  assign pc_inc   = pc + 1'b1;

  assign ld_ready = (state == ST_IDLE);
  assign busy     = (state == ST_RUN);
  assign dp_ctrl  = (state == ST_RUN) ? word_dp : '0;

  always_ff @(posedge clk) begin
    if (ld_valid && ld_ready) begin
      mem[ld_addr] <= ld_data;
    end
  end

  useq_stack #(
    .P_DEPTH (P_STACK_DEPTH),
    .P_WIDTH (P_LOG_MEMSIZE)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clr       (run_start),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    fault     = 1'b0;
    run_start = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
          run_start = 1'b1;
        end
      end
      ST_RUN: begin
        case (word_op)
          OP_NEXT: pc_nxt = pc_inc;
          OP_JC:   pc_nxt = cres ? word_arg : pc_inc;
          OP_JU:   pc_nxt = word_arg;
          OP_CALL: begin
            if (!stk_full) begin
              push   = 1'b1;
              pc_nxt = word_arg;
            end else begin
              fault = 1'b1;
            end
          end
          OP_RET: begin
            if (!stk_empty) begin
              pop    = 1'b1;
              pc_nxt = stk_top;
            end else begin
              fault = 1'b1;
            end
          end
          OP_LOOP: begin
            if (cnt != '0) begin
              cnt_nxt = cnt - 1'b1;
              pc_nxt  = word_arg;
            end else begin
              pc_nxt = pc_inc;
            end
          end
          OP_LDCNT: begin
            cnt_nxt = word_arg;
            pc_nxt  = pc_inc;
          end
          OP_HALT: begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
          default: pc_nxt = pc_inc;
        endcase
        // A fault leaves pc and cnt where they were for post-mortem inspection.
        if (fault) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      err <= 1'b0;
    end else if (fault) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// Directed self-checking bench for useq_sequencer: load, run control, loop,
// conditional jump, call/return, fault handling and mid-run reset.
module tb_useq_sequencer;

  localparam logic [2:0] NEXT  = 3'd0;
  localparam logic [2:0] JC    = 3'd1;
  localparam logic [2:0] JU    = 3'd2;
  localparam logic [2:0] CALL  = 3'd3;
  localparam logic [2:0] RET   = 3'd4;
  localparam logic [2:0] LOOP  = 3'd5;
  localparam logic [2:0] LDCNT = 3'd6;
  localparam logic [2:0] HALT  = 3'd7;
  localparam int         RUN_BOUND = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cres;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [11:0] ld_data;
  logic [4:0]  dp_ctrl;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  int         r_cycles;
  int         r_match;
  logic       r_done;
  logic       r_err;
  logic [4:0] r_trace [32];

  always #5 clk = ~clk;

  useq_sequencer #(
    .P_LOG_MEMSIZE    (4),
    .P_NUM_D_CTRLBITS (5),
    .P_STACK_DEPTH    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cres     (cres),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dp_ctrl  (dp_ctrl),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] addr, input logic [4:0] dp,
                           input logic [2:0] op, input logic [3:0] arg);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = {dp, op, arg};
    step();
    ld_valid = 1'b0;
  endtask

  // Pulses start, records dp_ctrl on every busy cycle, then samples done/err
  // on the first idle cycle.
  task automatic run_prog(input logic [4:0] match);
    r_cycles = 0;
    r_match  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (busy === 1'b1 && r_cycles < RUN_BOUND) begin
      if (r_cycles < 32) r_trace[r_cycles] = dp_ctrl;
      if (dp_ctrl === match) r_match++;
      r_cycles++;
      step();
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_timeout: busy=%b after %0d cycles, required 0", busy, r_cycles);
    end
    r_done = done;
    r_err  = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({busy, done, err, ld_ready, dp_ctrl} !== {1'b0, 1'b0, 1'b0, 1'b1, 5'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b ld_ready=%b dp=%h, required 0 0 0 1 00",
               busy, done, err, ld_ready, dp_ctrl);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_straight_line();
    load_word(4'd0, 5'h01, NEXT, 4'd0);
    load_word(4'd1, 5'h02, NEXT, 4'd0);
    load_word(4'd2, 5'h04, HALT, 4'd0);
    run_prog(5'h04);
    n_cmp++;
    if (r_cycles !== 3 || r_trace[0] !== 5'h01 || r_trace[1] !== 5'h02 || r_trace[2] !== 5'h04) begin
      n_fail++;
      $display("FAIL straight_trace: cycles=%0d dp=%h,%h,%h, required 3 cycles 01,02,04",
               r_cycles, r_trace[0], r_trace[1], r_trace[2]);
    end
    n_cmp++;
    if (r_done !== 1'b1 || r_err !== 1'b0 || dp_ctrl !== 5'h00) begin
      n_fail++;
      $display("FAIL straight_done: done=%b err=%b dp=%h, required 1 0 00", r_done, r_err, dp_ctrl);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL straight_done_pulse: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_loop();
    load_word(4'd0, 5'h00, LDCNT, 4'd3);
    load_word(4'd1, 5'h10, NEXT, 4'd0);
    load_word(4'd2, 5'h00, LOOP, 4'd1);
    load_word(4'd3, 5'h00, HALT, 4'd0);
    run_prog(5'h10);
    n_cmp++;
    if (r_cycles !== 10 || r_match !== 4) begin
      n_fail++;
      $display("FAIL loop_count: cycles=%0d dp10_hits=%0d, required 10 and 4", r_cycles, r_match);
    end
    n_cmp++;
    if (r_done !== 1'b1 || r_err !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_done: done=%b err=%b, required 1 0", r_done, r_err);
    end
  endtask

  task automatic test_cond_jump();
    load_word(4'd0, 5'h00, JC, 4'd5);
    load_word(4'd1, 5'h1F, HALT, 4'd0);
    load_word(4'd5, 5'h00, HALT, 4'd0);
    cres = 1'b1;
    run_prog(5'h1F);
    n_cmp++;
    if (r_cycles !== 2 || r_trace[1] !== 5'h00 || r_match !== 0) begin
      n_fail++;
      $display("FAIL jc_taken: cycles=%0d halt_dp=%h, required 2 and 00", r_cycles, r_trace[1]);
    end
    step();
    cres = 1'b0;
    run_prog(5'h1F);
    n_cmp++;
    if (r_cycles !== 2 || r_trace[1] !== 5'h1F || r_done !== 1'b1) begin
      n_fail++;
      $display("FAIL jc_not_taken: cycles=%0d halt_dp=%h done=%b, required 2 1F 1",
               r_cycles, r_trace[1], r_done);
    end
  endtask

  task automatic test_call_ret();
    load_word(4'd0, 5'h01, CALL, 4'd4);
    load_word(4'd1, 5'h02, HALT, 4'd0);
    load_word(4'd4, 5'h04, CALL, 4'd8);
    load_word(4'd5, 5'h05, RET, 4'd0);
    load_word(4'd8, 5'h08, RET, 4'd0);
    run_prog(5'h00);
    n_cmp++;
    if (r_cycles !== 5 || r_trace[0] !== 5'h01 || r_trace[1] !== 5'h04 || r_trace[2] !== 5'h08 ||
        r_trace[3] !== 5'h05 || r_trace[4] !== 5'h02) begin
      n_fail++;
      $display("FAIL call_ret_trace: cycles=%0d dp=%h,%h,%h,%h,%h, required 5 cycles 01,04,08,05,02",
               r_cycles, r_trace[0], r_trace[1], r_trace[2], r_trace[3], r_trace[4]);
    end
    n_cmp++;
    if (r_done !== 1'b1 || r_err !== 1'b0) begin
      n_fail++;
      $display("FAIL call_ret_done: done=%b err=%b, required 1 0", r_done, r_err);
    end
    // Third nested call overflows a depth-2 stack.
    load_word(4'd8, 5'h08, CALL, 4'd12);
    load_word(4'd12, 5'h0C, HALT, 4'd0);
    run_prog(5'h0C);
    n_cmp++;
    if (r_cycles !== 3 || r_match !== 0 || r_done !== 1'b1 || r_err !== 1'b1) begin
      n_fail++;
      $display("FAIL call_overflow: cycles=%0d hits=%0d done=%b err=%b, required 3 0 1 1",
               r_cycles, r_match, r_done, r_err);
    end
    step();
    n_cmp++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b done=%b busy=%b, required 1 0 0", err, done, busy);
    end
  endtask

  task automatic test_ret_empty();
    load_word(4'd0, 5'h0A, RET, 4'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || err !== 1'b0 || dp_ctrl !== 5'h0A) begin
      n_fail++;
      $display("FAIL ret_empty_start: busy=%b err=%b dp=%h, required 1 0 0A", busy, err, dp_ctrl);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_empty_fault: busy=%b err=%b done=%b, required 0 1 1", busy, err, done);
    end
    step();
  endtask

  task automatic test_start_with_load();
    ld_valid = 1'b1;
    ld_addr  = 4'd0;
    ld_data  = {5'h15, HALT, 4'd0};
    start    = 1'b1;
    step();
    ld_valid = 1'b0;
    start    = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || dp_ctrl !== 5'h15) begin
      n_fail++;
      $display("FAIL start_with_load: busy=%b dp=%h, required 1 15", busy, dp_ctrl);
    end
    step();
    step();
  endtask

  task automatic test_load_block_and_reset();
    load_word(4'd0, 5'h01, NEXT, 4'd0);
    load_word(4'd1, 5'h02, NEXT, 4'd0);
    load_word(4'd2, 5'h03, JU, 4'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 4'd1;
    ld_data  = {5'h1F, HALT, 4'd0};
    n_cmp++;
    if (ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_ready_run: ld_ready=%b, required 0", ld_ready);
    end
    step();
    step();
    step();
    ld_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || dp_ctrl !== 5'h02) begin
      n_fail++;
      $display("FAIL run_unaffected: busy=%b dp=%h, required 1 02", busy, dp_ctrl);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || dp_ctrl !== 5'h00 || err !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b dp=%h err=%b ld_ready=%b, required 0 0 00 0 1",
               busy, done, dp_ctrl, err, ld_ready);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: done=%b, required 0", done);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) r_trace[i] = 5'(i + 1);
      else       r_trace[i] = (i == 3) ? 5'h02 : 5'h03;
      n_cmp++;
      if (busy !== 1'b1 || dp_ctrl !== r_trace[i]) begin
        n_fail++;
        $display("FAIL rerun_cycle%0d: busy=%b dp=%h, required 1 %h", i, busy, dp_ctrl, r_trace[i]);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    cres     = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    test_reset();
    test_straight_line();
    test_loop();
    test_cond_jump();
    test_call_ret();
    test_ret_empty();
    test_start_with_load();
    test_load_block_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
